// File: rtl/sdram_arbit_if.sv
// Bus between the SDRAM arbiter (master) and the init/refresh/write/read sub-modules (slave side).
interface sdram_arbit_if;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned DQ_W   = 16;

    // sub-module requests, handshakes and command sources
    logic              flag_init_end;
    logic [CMD_W-1:0]  init_cmd;
    logic [ADDR_W-1:0] init_addr;
    logic              flag_ref_end;
    logic [CMD_W-1:0]  ref_cmd;
    logic [ADDR_W-1:0] ref_addr;
    logic              flag_wr_ask;
    logic              flag_wr_end;
    logic [CMD_W-1:0]  wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [BANK_W-1:0] wr_bank;
    logic [DQ_W-1:0]   wr_dq;
    logic              flag_rd_ask;
    logic              flag_rd_end;
    logic [CMD_W-1:0]  rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [BANK_W-1:0] rd_bank;

    // grants and pin-side signals
    logic              aref_en;
    logic              wr_en;
    logic              rd_en;
    logic [CMD_W-1:0]  sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BANK_W-1:0] sdram_bank;
    logic [DQ_W-1:0]   sdram_dq_out;
    logic              sdram_dq_oe;
    logic              ref_miss;

    modport master (
        input  flag_init_end, init_cmd, init_addr,
        input  flag_ref_end, ref_cmd, ref_addr,
        input  flag_wr_ask, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_dq,
        input  flag_rd_ask, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        output aref_en, wr_en, rd_en,
        output sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe, ref_miss
    );

    modport slave (
        output flag_init_end, init_cmd, init_addr,
        output flag_ref_end, ref_cmd, ref_addr,
        output flag_wr_ask, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_dq,
        output flag_rd_ask, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        input  aref_en, wr_en, rd_en,
        input  sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe, ref_miss
    );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM bus scheduler: grants init/refresh/write/read in turn, owns the refresh timer, muxes pins.
module sdram_arbit #(
    parameter int unsigned REF_CYCLES = 1500,
    parameter logic [3:0]  CMD_NOP    = 4'b0111
) (
    input  logic              sclk,
    input  logic              srst_n,
    sdram_arbit_if.master     bus
);
    localparam int unsigned CNT_W  = $clog2(REF_CYCLES);
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned BANK_W = 2;

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_ref_cnt;
    logic               r_ref_pend;
    logic               r_ref_miss;
    logic               r_last_wr;
    logic               w_wrap;

    logic               w_aref_en;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [3:0]         w_cmd;
    logic [ADDR_W-1:0]  w_addr;
    logic [BANK_W-1:0]  w_bank;
    logic               w_dq_oe;

    assign w_wrap = (r_state != S_INIT) && (r_ref_cnt == CNT_W'(REF_CYCLES - 1));

    // State register
    always_ff @(posedge sclk) begin
        if (!srst_n) r_state <= S_INIT;
        else         r_state <= w_state_nxt;
    end

    // Next-state: refresh first, then alternate write/read on a tie
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (bus.flag_init_end) w_state_nxt = S_ARBIT;
            S_ARBIT: begin
                if (r_ref_pend)                              w_state_nxt = S_AREF;
                else if (bus.flag_wr_ask && bus.flag_rd_ask) w_state_nxt = r_last_wr ? S_READ : S_WRITE;
                else if (bus.flag_wr_ask)                    w_state_nxt = S_WRITE;
                else if (bus.flag_rd_ask)                    w_state_nxt = S_READ;
                else                                         w_state_nxt = S_ARBIT;
            end
            S_AREF:  if (bus.flag_ref_end) w_state_nxt = S_ARBIT;
            S_WRITE: if (bus.flag_wr_end)  w_state_nxt = S_ARBIT;
            S_READ:  if (bus.flag_rd_end)  w_state_nxt = S_ARBIT;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // Remember which transfer type was granted last, for tie-breaking
    always_ff @(posedge sclk) begin
        if (!srst_n) begin
            r_last_wr <= 1'b0;
        end else if (r_state == S_ARBIT) begin
            if (w_state_nxt == S_WRITE)     r_last_wr <= 1'b1;
            else if (w_state_nxt == S_READ) r_last_wr <= 1'b0;
        end
    end

    // Refresh interval timer; a new interval beats a same-cycle refresh completion
    always_ff @(posedge sclk) begin
        if (!srst_n) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
            r_ref_miss <= 1'b0;
        end else begin
            if (r_state == S_INIT || w_wrap) r_ref_cnt <= '0;
            else                             r_ref_cnt <= r_ref_cnt + CNT_W'(1);

            if (w_wrap) begin
                r_ref_pend <= 1'b1;
                if (r_ref_pend) r_ref_miss <= 1'b1;
            end else if (r_state == S_AREF && bus.flag_ref_end) begin
                r_ref_pend <= 1'b0;
            end
        end
    end

    // Grants and pin mux; a pending refresh withdraws data grants to preempt the transfer
    always_comb begin
        w_aref_en = 1'b0;
        w_wr_en   = 1'b0;
        w_rd_en   = 1'b0;
        w_cmd     = CMD_NOP;
        w_addr    = '0;
        w_bank    = '0;
        w_dq_oe   = 1'b0;
        case (r_state)
            S_INIT: begin
                w_cmd  = bus.init_cmd;
                w_addr = bus.init_addr;
            end
            S_AREF: begin
                w_aref_en = 1'b1;
                w_cmd     = bus.ref_cmd;
                w_addr    = bus.ref_addr;
            end
            S_WRITE: begin
                w_wr_en = !r_ref_pend;
                w_cmd   = bus.wr_cmd;
                w_addr  = bus.wr_addr;
                w_bank  = bus.wr_bank;
                w_dq_oe = 1'b1;
            end
            S_READ: begin
                w_rd_en = !r_ref_pend;
                w_cmd   = bus.rd_cmd;
                w_addr  = bus.rd_addr;
                w_bank  = bus.rd_bank;
            end
            default: ;
        endcase
    end

    assign bus.aref_en      = w_aref_en;
    assign bus.wr_en        = w_wr_en;
    assign bus.rd_en        = w_rd_en;
    assign bus.sdram_cmd    = w_cmd;
    assign bus.sdram_addr   = w_addr;
    assign bus.sdram_bank   = w_bank;
    assign bus.sdram_dq_out = bus.wr_dq;
    assign bus.sdram_dq_oe  = w_dq_oe;
    assign bus.ref_miss     = r_ref_miss;
endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios, per-cycle reference model, literal spot checks.
module tb_sdram_arbit;
    localparam int unsigned REF = 20;
    localparam logic [3:0]  NOP = 4'b0111;
    localparam logic [3:0]  INIT_CMD = 4'h1, REF_CMD = 4'h2, WR_CMD = 4'h3, RD_CMD = 4'h5;
    localparam logic [11:0] INIT_ADDR = 12'h400, REF_ADDR = 12'h123, WR_ADDR = 12'h0A5, RD_ADDR = 12'h35A;
    localparam logic [1:0]  WR_BANK = 2'd2, RD_BANK = 2'd1;
    localparam int M_INIT = 0, M_ARBIT = 1, M_AREF = 2, M_WRITE = 3, M_READ = 4;

    logic sclk;
    logic srst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    sdram_arbit_if bus_if();

    sdram_arbit #(.REF_CYCLES(REF), .CMD_NOP(NOP)) dut (
        .sclk   (sclk),
        .srst_n (srst_n),
        .bus    (bus_if)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: mode of the bus, cycles elapsed since init, refresh debt
    int m_mode;
    int m_since;
    bit m_pend, m_miss, m_last_wr, m_valid = 1'b0;

    always @(posedge sclk) begin
        int  nxt;
        bit  wrap;
        cyc++;
        if (!srst_n) begin
            m_mode = M_INIT; m_since = 0; m_pend = 0; m_miss = 0; m_last_wr = 0; m_valid = 1;
        end else if (m_valid) begin
            wrap = (m_mode != M_INIT) && ((m_since % REF) == REF - 1);
            nxt  = m_mode;
            if (m_mode == M_INIT && bus_if.flag_init_end) nxt = M_ARBIT;
            if (m_mode == M_AREF && bus_if.flag_ref_end)  nxt = M_ARBIT;
            if (m_mode == M_WRITE && bus_if.flag_wr_end)  nxt = M_ARBIT;
            if (m_mode == M_READ && bus_if.flag_rd_end)   nxt = M_ARBIT;
            if (m_mode == M_ARBIT) begin
                if (m_pend) nxt = M_AREF;
                else if (bus_if.flag_wr_ask && (!bus_if.flag_rd_ask || !m_last_wr)) nxt = M_WRITE;
                else if (bus_if.flag_rd_ask) nxt = M_READ;
            end
            if (wrap) begin
                if (m_pend) m_miss = 1;
                m_pend = 1;
            end else if (m_mode == M_AREF && bus_if.flag_ref_end) begin
                m_pend = 0;
            end
            if (m_mode == M_ARBIT && nxt == M_WRITE) m_last_wr = 1;
            if (m_mode == M_ARBIT && nxt == M_READ)  m_last_wr = 0;
            m_since = (m_mode == M_INIT) ? 0 : m_since + 1;
            m_mode  = nxt;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge sclk) begin
        logic [3:0]  e_cmd;
        logic [11:0] e_addr;
        logic [1:0]  e_bank;
        if (m_valid) begin
            case (m_mode)
                M_INIT:  begin e_cmd = INIT_CMD; e_addr = INIT_ADDR; e_bank = 2'd0;    end
                M_AREF:  begin e_cmd = REF_CMD;  e_addr = REF_ADDR;  e_bank = 2'd0;    end
                M_WRITE: begin e_cmd = WR_CMD;   e_addr = WR_ADDR;   e_bank = WR_BANK; end
                M_READ:  begin e_cmd = RD_CMD;   e_addr = RD_ADDR;   e_bank = RD_BANK; end
                default: begin e_cmd = NOP;      e_addr = 12'd0;     e_bank = 2'd0;    end
            endcase
            chk("m_aref_en", 32'(bus_if.aref_en), 32'(m_mode == M_AREF));
            chk("m_wr_en",   32'(bus_if.wr_en),   32'(m_mode == M_WRITE && !m_pend));
            chk("m_rd_en",   32'(bus_if.rd_en),   32'(m_mode == M_READ && !m_pend));
            chk("m_cmd",     32'(bus_if.sdram_cmd),  32'(e_cmd));
            chk("m_addr",    32'(bus_if.sdram_addr), 32'(e_addr));
            chk("m_bank",    32'(bus_if.sdram_bank), 32'(e_bank));
            chk("m_dq_out",  32'(bus_if.sdram_dq_out), 32'(bus_if.wr_dq));
            chk("m_dq_oe",   32'(bus_if.sdram_dq_oe),  32'(m_mode == M_WRITE));
            chk("m_ref_miss", 32'(bus_if.ref_miss),   32'(m_miss));
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sclk);
            #2;
            bus_if.wr_dq = 16'($urandom);
        end
    endtask

    // Wait for a data grant, servicing any refresh on the way; kind 1=write, 2=read, 0=timeout
    task automatic wait_grant(output int kind);
        kind = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus_if.sdram_cmd == WR_CMD) begin kind = 1; break; end
            if (bus_if.sdram_cmd == RD_CMD) begin kind = 2; break; end
            if (bus_if.aref_en) begin
                bus_if.flag_ref_end = 1'b1;
                tick();
                bus_if.flag_ref_end = 1'b0;
            end else begin
                tick();
            end
        end
        if (kind == 0) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int kind;
        bit seen;
        srst_n = 1'b0;
        bus_if.flag_init_end = 0; bus_if.flag_ref_end = 0;
        bus_if.flag_wr_ask = 0; bus_if.flag_wr_end = 0;
        bus_if.flag_rd_ask = 0; bus_if.flag_rd_end = 0;
        bus_if.init_cmd = INIT_CMD; bus_if.init_addr = INIT_ADDR;
        bus_if.ref_cmd  = REF_CMD;  bus_if.ref_addr  = REF_ADDR;
        bus_if.wr_cmd = WR_CMD; bus_if.wr_addr = WR_ADDR; bus_if.wr_bank = WR_BANK; bus_if.wr_dq = 16'h0;
        bus_if.rd_cmd = RD_CMD; bus_if.rd_addr = RD_ADDR; bus_if.rd_bank = RD_BANK;

        // Reset state
        tick(3);
        chk("rst_cmd", 32'(bus_if.sdram_cmd), 32'h1);
        chk("rst_aref_en", 32'(bus_if.aref_en), 32'd0);
        chk("rst_dq_oe", 32'(bus_if.sdram_dq_oe), 32'd0);
        srst_n = 1'b1;

        // Init done at cycle 10, then idle NOP and first refresh 20 cycles later
        tick(6);
        bus_if.flag_init_end = 1'b1;
        tick();
        bus_if.flag_init_end = 1'b0;
        chk("idle_nop", 32'(bus_if.sdram_cmd), 32'h7);
        chk("idle_addr", 32'(bus_if.sdram_addr), 32'h0);
        tick(20);
        chk("pend_not_yet_aref", 32'(bus_if.aref_en), 32'd0);
        tick();
        chk("first_aref_en", 32'(bus_if.aref_en), 32'd1);
        chk("first_aref_cmd", 32'(bus_if.sdram_cmd), 32'h2);
        bus_if.flag_ref_end = 1'b1;
        tick();
        bus_if.flag_ref_end = 1'b0;

        // Write/read tie alternates, starting with write
        bus_if.flag_wr_ask = 1'b1;
        bus_if.flag_rd_ask = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_grant(kind);
            chk("alt_order", 32'(kind), (g % 2 == 0) ? 32'd1 : 32'd2);
            chk("alt_dq_oe", 32'(bus_if.sdram_dq_oe), (g % 2 == 0) ? 32'd1 : 32'd0);
            tick(6);
            if (kind == 1) bus_if.flag_wr_end = 1'b1;
            else           bus_if.flag_rd_end = 1'b1;
            tick();
            bus_if.flag_wr_end = 1'b0;
            bus_if.flag_rd_end = 1'b0;
        end
        bus_if.flag_wr_ask = 1'b0;
        bus_if.flag_rd_ask = 1'b0;

        // Refresh preempts a write, then the write resumes
        bus_if.flag_wr_ask = 1'b1;
        wait_grant(kind);
        chk("pre_grant", 32'(kind), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!bus_if.wr_en) begin seen = 1'b1; break; end
            tick();
        end
        chk("pre_drop_seen", 32'(seen), 32'd1);
        chk("pre_drop_cmd", 32'(bus_if.sdram_cmd), 32'h3);
        bus_if.flag_wr_end = 1'b1;
        tick();
        bus_if.flag_wr_end = 1'b0;
        chk("pre_arbit_nop", 32'(bus_if.sdram_cmd), 32'h7);
        tick();
        chk("pre_aref_en", 32'(bus_if.aref_en), 32'd1);
        bus_if.flag_ref_end = 1'b1;
        tick();
        bus_if.flag_ref_end = 1'b0;
        chk("pre_back_nop", 32'(bus_if.sdram_cmd), 32'h7);
        tick();
        chk("pre_resume_wr_en", 32'(bus_if.wr_en), 32'd1);
        chk("pre_resume_cmd", 32'(bus_if.sdram_cmd), 32'h3);
        bus_if.flag_wr_end = 1'b1;
        bus_if.flag_wr_ask = 1'b0;
        tick();
        bus_if.flag_wr_end = 1'b0;

        // Long read misses a refresh interval; the miss is sticky
        bus_if.flag_rd_ask = 1'b1;
        wait_grant(kind);
        chk("miss_grant", 32'(kind), 32'd2);
        tick(45);
        chk("miss_set", 32'(bus_if.ref_miss), 32'd1);
        chk("miss_rd_en", 32'(bus_if.rd_en), 32'd0);
        bus_if.flag_rd_end = 1'b1;
        bus_if.flag_rd_ask = 1'b0;
        tick();
        bus_if.flag_rd_end = 1'b0;
        chk("miss_arbit_nop", 32'(bus_if.sdram_cmd), 32'h7);
        tick();
        chk("miss_aref_en", 32'(bus_if.aref_en), 32'd1);
        bus_if.flag_ref_end = 1'b1;
        tick();
        bus_if.flag_ref_end = 1'b0;
        chk("miss_sticky", 32'(bus_if.ref_miss), 32'd1);

        // Reset during a write
        bus_if.flag_wr_ask = 1'b1;
        wait_grant(kind);
        chk("rw_grant", 32'(kind), 32'd1);
        srst_n = 1'b0;
        tick();
        chk("rw_cmd", 32'(bus_if.sdram_cmd), 32'h1);
        chk("rw_addr", 32'(bus_if.sdram_addr), 32'h400);
        chk("rw_wr_en", 32'(bus_if.wr_en), 32'd0);
        chk("rw_aref_en", 32'(bus_if.aref_en), 32'd0);
        chk("rw_dq_oe", 32'(bus_if.sdram_dq_oe), 32'd0);
        chk("rw_miss_clr", 32'(bus_if.ref_miss), 32'd0);
        srst_n = 1'b1;
        bus_if.flag_wr_ask = 1'b0;
        tick(3);
        chk("rw_hold_init", 32'(bus_if.sdram_cmd), 32'h1);
        bus_if.flag_init_end = 1'b1;
        tick();
        bus_if.flag_init_end = 1'b0;
        tick();
        chk("rw_no_pend", 32'(bus_if.aref_en), 32'd0);
        chk("rw_nop", 32'(bus_if.sdram_cmd), 32'h7);

        // Foreign end pulses are ignored in refresh
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.aref_en) begin seen = 1'b1; break; end
            tick();
        end
        chk("ign_aref_seen", 32'(seen), 32'd1);
        bus_if.flag_wr_end = 1'b1;
        bus_if.flag_rd_end = 1'b1;
        tick();
        bus_if.flag_wr_end = 1'b0;
        bus_if.flag_rd_end = 1'b0;
        chk("ign_still_aref", 32'(bus_if.aref_en), 32'd1);
        tick();
        chk("ign_aref_cmd", 32'(bus_if.sdram_cmd), 32'h2);
        bus_if.flag_ref_end = 1'b1;
        tick();
        bus_if.flag_ref_end = 1'b0;
        chk("ign_exit_nop", 32'(bus_if.sdram_cmd), 32'h7);
        chk("ign_exit_aref", 32'(bus_if.aref_en), 32'd0);

        tick(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Top-level scheduler for the SDRAM controller; shares the single SDRAM command/address/data bus between the init, auto-refresh, write and read sub-modules.
- Owns the auto-refresh interval timer.
- Grants the bus through enable levels and the sub-modules' ask/end flag handshakes.
- Multiplexes the granted sub-module's command, address, bank and write data onto the pins.

Parameters:
- REF_CYCLES, 1500, sclk cycles between refresh requests (15 us at 100 MHz); minimum 8.
- CMD_NOP, 4'b0111, command driven while no sub-module is granted.

Ports:
sclk  in  1  system clock, all logic on rising edge
srst_n  in  1  reset, synchronous, active-low
flag_init_end  in  1  init sequence complete (1-cycle pulse)
init_cmd  in  4  init module command
init_addr  in  12  init module address
flag_ref_end  in  1  refresh module finished (1-cycle pulse)
ref_cmd  in  4  refresh module command
ref_addr  in  12  refresh module address
flag_wr_ask  in  1  write module requests bus (level)
flag_wr_end  in  1  write module released bus after precharge (pulse)
wr_cmd  in  4  write module command
wr_addr  in  12  write module address
wr_bank  in  2  write module bank
wr_dq  in  16  write data
flag_rd_ask  in  1  read module requests bus (level)
flag_rd_end  in  1  read module released bus (pulse)
rd_cmd  in  4  read module command
rd_addr  in  12  read module address
rd_bank  in  2  read module bank
aref_en  out  1  grant to refresh module
wr_en  out  1  grant to write module
rd_en  out  1  grant to read module
sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to pins
sdram_addr  out  12  address to pins
sdram_bank  out  2  bank to pins
sdram_dq_out  out  16  write data to pins
sdram_dq_oe  out  1  data pin output enable
ref_miss  out  1  sticky: refresh interval elapsed while a refresh was already pending

Behaviour:

State machine:
- One-hot states: S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ.
- Reset state is S_INIT.
- Transitions are registered and evaluated every cycle.
- S_INIT -> S_ARBIT on flag_init_end.
- S_ARBIT priority, decided in one cycle:
  1. ref_pend -> S_AREF.
  2. Else flag_wr_ask & flag_rd_ask -> the type NOT served last (last_wr flag; reset value 0, so write wins the first tie).
  3. Else flag_wr_ask -> S_WRITE.
  4. Else flag_rd_ask -> S_READ.
  5. Else stay in S_ARBIT.
- last_wr is set on entry to S_WRITE and cleared on entry to S_READ.
- S_AREF -> S_ARBIT on flag_ref_end.
- S_WRITE -> S_ARBIT on flag_wr_end.
- S_READ -> S_ARBIT on flag_rd_end.
- End pulses arriving in a non-matching state are ignored.

Enables (combinational):
- aref_en = (state==S_AREF).
- wr_en = (state==S_WRITE) & !ref_pend.
- rd_en = (state==S_READ) & !ref_pend.
- Dropping wr_en/rd_en while ref_pend is set is the preemption mechanism: the sub-module finishes its current burst, precharges, pulses its end flag and re-raises its ask.
- Arbitration then services the refresh first, then resumes the preempted transfer.

Refresh timer:
- ref_cnt holds at 0 while state==S_INIT.
- Otherwise it counts 0..REF_CYCLES-1 and wraps.
- At the wrap cycle (ref_cnt==REF_CYCLES-1): ref_pend <= 1.
- ref_pend clears on flag_ref_end while in S_AREF.
- If the wrap and flag_ref_end occur in the same cycle, the set wins: ref_pend stays 1.
- If the wrap occurs while ref_pend is already 1, ref_miss <= 1. ref_miss is cleared only by reset.

Pin mux (combinational, by state):
- S_INIT: init_cmd / init_addr, bank 0.
- S_AREF: ref_cmd / ref_addr, bank 0.
- S_WRITE: wr_cmd / wr_addr / wr_bank.
- S_READ: rd_cmd / rd_addr / rd_bank.
- S_ARBIT: CMD_NOP, address 0, bank 0.
- sdram_dq_out = wr_dq at all times.
- sdram_dq_oe = (state==S_WRITE).

Reset values (srst_n low at a rising edge):
- state = S_INIT, ref_cnt = 0, ref_pend = 0, ref_miss = 0, last_wr = 0.
- As a result aref_en = wr_en = rd_en = 0, sdram_dq_oe = 0, and the pins follow init_cmd/init_addr.
- Reset mid-transfer returns to S_INIT immediately, with no precharge issued by this block.

Test Plan (REF_CYCLES=20):
- Reset, pulse flag_init_end at cycle 10 -> S_ARBIT at cycle 11; sdram_cmd = 4'b0111 with no asks; first ref_pend 20 cycles later; aref_en high the next cycle.
- flag_wr_ask & flag_rd_ask asserted together repeatedly, ends pulsed 6 cycles after each grant -> grants alternate W,R,W,R starting with W; sdram_dq_oe high only during W.
- In S_WRITE, let the timer wrap -> wr_en drops the same cycle. After flag_wr_end -> S_AREF with aref_en=1, then S_WRITE again once flag_ref_end pulses while flag_wr_ask is held.
- Hold S_READ (no flag_rd_end) for 45 cycles -> ref_miss rises at the second wrap and stays 1 after a later flag_ref_end.
- Assert srst_n low for 1 cycle while in S_WRITE -> next cycle state S_INIT, all enables 0, ref_pend 0, pins show init_cmd.
- In S_AREF, pulse flag_wr_end and flag_rd_end -> no state change; only flag_ref_end returns to S_ARBIT.
